// File: rtl/dpmul_pkg.sv
// dpmul_pkg -- shared types and constants for the dual-port multiply engine.
// rev 1.0
`default_nettype none

package dpmul_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;
  localparam int PROD_W = 32;

  localparam logic [BYTE_W-1:0] DEF_OP_BASE   = 8'd0;
  localparam logic [BYTE_W-1:0] DEF_PROD_BASE = 8'd64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_MUL   = 3'd2,
    ST_STORE = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  // Each pair occupies four consecutive bytes starting at base + 4*j.
  function automatic logic [BYTE_W-1:0] pair_addr(input logic [BYTE_W-1:0] base,
                                                  input logic [5:0]        j,
                                                  input logic [1:0]        k);
    return base + {j, 2'b00} + {6'b0, k};
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul16x16_seq.sv
// mul16x16_seq -- 16x16 unsigned radix-2 shift-add multiplier, 16 cycles per product.
// rev 1.0
`default_nettype none

module mul16x16_seq
  import dpmul_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic              busy,
  output logic              valid,
  output logic [PROD_W-1:0] product
);

  logic [PROD_W-1:0] mcand;
  logic [WORD_W-1:0] mplier;
  logic [4:0]        cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      valid   <= 1'b0;
    end else if (load) begin
      product <= '0;
      mcand   <= {{(PROD_W-WORD_W){1'b0}}, a};
      mplier  <= b;
      cnt     <= 5'd16;
      busy    <= 1'b1;
      valid   <= 1'b0;
    end else if (busy) begin
      if (mplier[0])
        product <= product + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 5'd1;
      if (cnt == 5'd1) begin
        busy  <= 1'b0;
        valid <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dpmul_engine.sv
// dpmul_engine -- reads NUM_PAIRS 16-bit operand pairs, multiplies, writes 32-bit products back.
// rev 1.0
`default_nettype none

module dpmul_engine
  import dpmul_pkg::*;
#(
  parameter int                NUM_PAIRS = 16,
  parameter logic [BYTE_W-1:0] OP_BASE   = DEF_OP_BASE,
  parameter logic [BYTE_W-1:0] PROD_BASE = DEF_PROD_BASE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  output logic [BYTE_W-1:0] mem_addr,
  input  logic [BYTE_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [BYTE_W-1:0] mem_wr_data
);

  localparam int          JW     = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  localparam logic [JW-1:0] LAST_J = JW'(NUM_PAIRS - 1);

  if (int'(PROD_BASE) + 4*NUM_PAIRS - 1 > 255) begin : g_range_check
    $error("dpmul_engine: product area exceeds 256-byte memory");
  end

  state_t              state;
  logic [3:0]          step;
  logic [JW-1:0]       j;
  logic                start_q;
  logic [WORD_W-1:0]   op_a;
  logic [BYTE_W-1:0]   op_b_hi;

  logic                mul_load;
  logic                mul_busy;
  logic                mul_valid;
  logic [PROD_W-1:0]   product;

  // Last operand byte goes straight from the bus into the multiplier.
  assign mul_load = (state == ST_LOAD) && (step == 4'd3);

  mul16x16_seq u_mul (
    .clk     (clk),
    .reset   (reset),
    .load    (mul_load),
    .a       (op_a),
    .b       ({op_b_hi, mem_rd_data}),
    .busy    (mul_busy),
    .valid   (mul_valid),
    .product (product)
  );

  always_comb begin
    mem_wr_data = '0;
    if (state == ST_STORE && mul_valid && !mul_busy) begin
      case (step[1:0])
        2'd0:    mem_wr_data = product[31:24];
        2'd1:    mem_wr_data = product[23:16];
        2'd2:    mem_wr_data = product[15:8];
        default: mem_wr_data = product[7:0];
      endcase
    end
  end

  // start_q clears on reset so a start held low out of reset never reads as a falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      step      <= '0;
      j         <= '0;
      start_q   <= 1'b0;
      op_a      <= '0;
      op_b_hi   <= '0;
      done      <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_addr  <= '0;
    end else begin
      start_q <= start;
      case (state)
        ST_IDLE: begin
          if (!start && start_q) begin
            state    <= ST_LOAD;
            step     <= '0;
            j        <= '0;
            mem_addr <= OP_BASE;
          end
        end
        ST_LOAD, ST_MUL, ST_STORE: begin
          if (start) begin
            state     <= ST_IDLE;
            step      <= '0;
            mem_wr_en <= 1'b0;
            mem_addr  <= '0;
          end else if (state == ST_LOAD) begin
            case (step[1:0])
              2'd0:    op_a[15:8] <= mem_rd_data;
              2'd1:    op_a[7:0]  <= mem_rd_data;
              2'd2:    op_b_hi    <= mem_rd_data;
              default: ;
            endcase
            if (step == 4'd3) begin
              state    <= ST_MUL;
              step     <= '0;
              mem_addr <= '0;
            end else begin
              step     <= step + 4'd1;
              mem_addr <= pair_addr(OP_BASE, 6'(j), step[1:0] + 2'd1);
            end
          end else if (state == ST_MUL) begin
            if (step == 4'd15) begin
              state     <= ST_STORE;
              step      <= '0;
              mem_wr_en <= 1'b1;
              mem_addr  <= pair_addr(PROD_BASE, 6'(j), 2'd0);
            end else begin
              step <= step + 4'd1;
            end
          end else begin
            if (step == 4'd3) begin
              step      <= '0;
              mem_wr_en <= 1'b0;
              if (j == LAST_J) begin
                state    <= ST_FIN;
                done     <= 1'b1;
                mem_addr <= '0;
              end else begin
                state    <= ST_LOAD;
                j        <= j + 1'b1;
                mem_addr <= pair_addr(OP_BASE, 6'(j + 1'b1), 2'd0);
              end
            end else begin
              step     <= step + 4'd1;
              mem_addr <= pair_addr(PROD_BASE, 6'(j), step[1:0] + 2'd1);
            end
          end
        end
        ST_FIN: begin
          if (start) begin
            state <= ST_IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          done      <= 1'b0;
          mem_wr_en <= 1'b0;
          mem_addr  <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dpmul_engine.sv
// tb_dpmul_engine -- directed self-checking bench with a behavioural 256x8 memory.
// rev 1.0
`default_nettype none

module tb_dpmul_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       done;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;

  logic [7:0]  mem   [0:255];
  logic [31:0] exp_p [0:15];

  int n_checks = 0;
  int n_pass   = 0;
  int wr_cnt   = 0;
  int addr_cnt = 0;

  always #5 clk = ~clk;

  dpmul_engine dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .done        (done),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data)
  );

  assign mem_rd_data = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wr_en) begin
      mem[mem_addr] <= mem_wr_data;
      wr_cnt        <= wr_cnt + 1;
    end
    if (mem_addr != 8'd0)
      addr_cnt <= addr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, want);
  endtask

  task automatic set_pair(input int j, input logic [15:0] a, input logic [15:0] b);
    mem[4*j]   <= a[15:8];
    mem[4*j+1] <= a[7:0];
    mem[4*j+2] <= b[15:8];
    mem[4*j+3] <= b[7:0];
    exp_p[j]    = {16'd0, b} * {16'd0, a};
  endtask

  task automatic fill_pattern(input int first);
    for (int j = first; j < 16; j++)
      set_pair(j, 16'(j * 16'h1357 + 1), 16'(16'hF00F - j * 16'h0123));
  endtask

  task automatic clear_products();
    for (int i = 64; i < 128; i++) mem[i] <= 8'hEE;
    @(negedge clk);
  endtask

  function automatic logic [31:0] prod_at(input int j);
    return {mem[64+4*j], mem[65+4*j], mem[66+4*j], mem[67+4*j]};
  endfunction

  // Falling start edge launches a run; checks latency, write count, every product, done handshake.
  task automatic run_and_check(input string tag);
    int lat;
    int w0;
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    w0 = wr_cnt;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check({tag, " load_addr1"}, {24'd0, mem_addr}, 32'd1);
    lat = 1;
    while (!done && lat < 1000) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, lat, 384);
    check({tag, " writes"}, wr_cnt - w0, 64);
    for (int j = 0; j < 16; j++)
      check($sformatf("%s p%0d", tag, j), prod_at(j), exp_p[j]);
    @(negedge clk);
    check({tag, " done_hold"}, {31'd0, done}, 32'd1);
    check({tag, " fin_wr_en"}, {31'd0, mem_wr_en}, 32'd0);
    start = 1'b1;
    @(posedge clk); #1;
    check({tag, " done_drop"}, {31'd0, done}, 32'd0);
  endtask

  task automatic launch();
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int a0;
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    #12;
    check("rst done",    {31'd0, done},      32'd0);
    check("rst wr_en",   {31'd0, mem_wr_en}, 32'd0);
    check("rst addr",    {24'd0, mem_addr},  32'd0);
    check("rst wr_data", {24'd0, mem_wr_data}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Start low straight out of reset must never launch a run.
    w0 = wr_cnt; a0 = addr_cnt;
    repeat (1000) @(negedge clk);
    check("idle0 writes", wr_cnt - w0, 0);
    check("idle0 addr",   addr_cnt - a0, 0);
    check("idle0 done",   {31'd0, done}, 32'd0);

    set_pair(0, 16'h0003, 16'h0005);
    fill_pattern(1);
    clear_products();
    run_and_check("runA");
    check("runA bytes64", prod_at(0), 32'h0000_000F);

    set_pair(0, 16'hFFFF, 16'hFFFF);
    set_pair(1, 16'h0000, 16'h1234);
    set_pair(2, 16'hABCD, 16'h0000);
    set_pair(3, 16'h0001, 16'hFFFF);
    set_pair(4, 16'h8000, 16'h0002);
    fill_pattern(5);
    clear_products();
    run_and_check("runB");
    check("runB ffff2", prod_at(0), 32'hFFFE_0001);
    check("runB zeroA", prod_at(1), 32'h0000_0000);
    check("runB zeroB", prod_at(2), 32'h0000_0000);
    check("runB carry", prod_at(4), 32'h0001_0000);

    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 16; j++)
        set_pair(j, 16'($urandom), 16'($urandom));
      clear_products();
      run_and_check($sformatf("rnd%0d", r));
    end

    // Abort while loading pair 2 (cycle 50 after launch).
    fill_pattern(0);
    clear_products();
    launch();
    repeat (50) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    check("abort addr",  {24'd0, mem_addr},  32'd0);
    check("abort wr_en", {31'd0, mem_wr_en}, 32'd0);
    w0 = wr_cnt;
    repeat (500) @(negedge clk);
    check("abort writes", wr_cnt - w0, 0);
    check("abort done",   {31'd0, done}, 32'd0);
    check("abort p1",     prod_at(1), exp_p[1]);
    check("abort p2",     prod_at(2), 32'hEEEE_EEEE);
    clear_products();
    run_and_check("post_abort");

    // Reset in the middle of pair 7's multiply.
    clear_products();
    launch();
    repeat (180) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rstmul done",    {31'd0, done},        32'd0);
    check("rstmul wr_en",   {31'd0, mem_wr_en},   32'd0);
    check("rstmul addr",    {24'd0, mem_addr},    32'd0);
    check("rstmul wr_data", {24'd0, mem_wr_data}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    w0 = wr_cnt;
    repeat (100) @(negedge clk);
    check("rstmul idle writes", wr_cnt - w0, 0);
    check("rstmul idle done",   {31'd0, done}, 32'd0);
    clear_products();
    run_and_check("post_rstmul");

    // Reset while pair 7's product is being stored: strobe must drop without a clock edge.
    clear_products();
    launch();
    repeat (189) @(posedge clk);
    #2;
    check("pre_rststore wr_en", {31'd0, mem_wr_en}, 32'd1);
    check("pre_rststore addr",  {24'd0, mem_addr},  32'd93);
    reset = 1'b1;
    #1;
    check("rststore wr_en",   {31'd0, mem_wr_en},   32'd0);
    check("rststore addr",    {24'd0, mem_addr},    32'd0);
    check("rststore wr_data", {24'd0, mem_wr_data}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    clear_products();
    run_and_check("post_rststore");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
